cmd_sequencer: RTL

- Parses the header-plus-operand byte stream into complete commands and dispatches each one to the CPU execution unit or the memory unit.
- Supported commands: CPU NOOP/ADD/SUB and memory MWAIT/LOAD_RGR/STORE_RGR/COPY.
- Sits between the command source (generator/driver side) and the my_design datapath, and serialises execution with one command in flight at a time.
- Reports illegal headers and unit timeouts, and counts completed commands.

---
 rtl/cmd_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: parses header+operand byte stream and dispatches commands to CPU or memory unit
module cmd_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             cpu_req,
  output logic [1:0]       cpu_op,
  output logic [7:0]       cpu_op1,
  output logic [7:0]       cpu_op2,
  input  logic             cpu_done,
  output logic             mem_req,
  output logic [1:0]       mem_op,
  output logic [7:0]       mem_reg,
  output logic [15:0]      mem_src,
  output logic [15:0]      mem_dst,
  input  logic             mem_done,
  output logic             err,
  output logic             busy,
  output logic [CNT_W-1:0] cmd_count
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, COLLECT, WAIT_CPU, WAIT_MEM} state_t;
  state_t state, state_n;
  logic          is_mem;
  logic [1:0]    code_q;
  logic [2:0]    left;
  logic [23:0]   sh;
  logic [TW-1:0] tcnt;
  logic          acc, hdr, legal, len1, last, done, tout, waiting;
  logic [31:0]   full;
  // Header decode, completion/timeout detection and next-state selection
  always_comb begin
    acc = in_valid && in_ready;
    hdr = state == IDLE && acc;
    legal = (in_data[7:6] == 2'b00 && in_data[5:0] <= 6'd2) || (in_data[7:6] == 2'b01 && in_data[5:0] <= 6'd3);
    len1 = in_data[5:0] == 6'd0;
    last = state == COLLECT && acc && left == 3'd1;
    done = (state == WAIT_CPU && cpu_done) || (state == WAIT_MEM && mem_done);
    waiting = state == WAIT_CPU || state == WAIT_MEM;
    tout = waiting && !done && tcnt == TW'(TIMEOUT - 1);
    full = {sh, in_data};
    state_n = state;
    case (state)
      IDLE:    state_n = hdr && legal && !len1 ? COLLECT : IDLE;
      COLLECT: state_n = last ? (is_mem ? WAIT_MEM : WAIT_CPU) : COLLECT;
      default: state_n = done || tout ? IDLE : state;
    endcase
  end
  // State register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  assign busy = state != IDLE;
  // Operand capture, request issue/retire, timeout counting, error and completion count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b0;
      cpu_req <= 1'b0;
      cpu_op <= '0;
      cpu_op1 <= '0;
      cpu_op2 <= '0;
      mem_req <= 1'b0;
      mem_op <= '0;
      mem_reg <= '0;
      mem_src <= '0;
      mem_dst <= '0;
      err <= 1'b0;
      cmd_count <= '0;
      is_mem <= 1'b0;
      code_q <= '0;
      left <= '0;
      sh <= '0;
      tcnt <= '0;
    end else begin
      in_ready <= state_n == IDLE || state_n == COLLECT;
      err <= (hdr && !legal) || tout;
      cmd_count <= cmd_count + CNT_W'((hdr && legal && len1) || done);
      if (hdr) begin
        is_mem <= in_data[6];
        code_q <= in_data[1:0];
        left <= in_data[6] ? (in_data[1:0] == 2'd3 ? 3'd4 : 3'd3) : 3'd2;
      end
      if (state == COLLECT && acc) begin
        sh <= full[23:0];
        left <= left - 3'd1;
      end
      tcnt <= waiting && !done ? tcnt + TW'(1) : '0;
      if (last && !is_mem) begin
        cpu_req <= 1'b1;
        cpu_op <= code_q;
        cpu_op1 <= full[15:8];
        cpu_op2 <= full[7:0];
      end
      if (last && is_mem) begin
        mem_req <= 1'b1;
        mem_op <= code_q;
        mem_reg <= code_q == 2'd3 ? 8'd0 : full[23:16];
        mem_src <= code_q == 2'd3 ? full[31:16] : full[15:0];
        mem_dst <= code_q == 2'd3 ? full[15:0] : 16'd0;
      end
      if (done || tout) begin
        cpu_req <= 1'b0;
        mem_req <= 1'b0;
      end
    end
  end
endmodule
